// File: rtl/fixed_accumulate.sv
// fixed_accumulate
// ----------------
// Frame accumulator for signed fixed-point sample streams.
// Sums exactly LENGTH valid samples per frame in a widened accumulator.
// At the end of each frame it emits one BITS-wide result: the sum, or the
// frame mean when AVERAGE = 1.
//
// Parameters:
//   BITS      sample/result width (two's complement)
//   PRECISION fixed-point format tag; informational only, no rescale is done
//   LENGTH    samples per frame, power of two in 2..256
//   AVERAGE   0 = output sum, 1 = output sum >>> log2(LENGTH)
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset (also zeroes c/overflow)
//   clear         discards the partial frame; c/overflow hold
//   in_valid      a is valid this cycle
//   a             signed sample
//   out_valid     one-cycle pulse, c and overflow valid
//   c             frame result, held until the next result
//   overflow      frame sum was outside the BITS range (sum mode only)
//   sample_count  samples accepted in the current frame
//
// Optional feature:
//   FIXED_ACCUMULATE_SATURATE_EN  when defined, sum-mode results clamp to
//   the BITS range on overflow; otherwise they wrap.

module fixed_accumulate #(
  parameter int BITS      = 8,
  parameter     PRECISION = "FIXED_04_04",
  parameter int LENGTH    = 4,
  parameter int AVERAGE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [BITS-1:0]            a,
  output logic                       out_valid,
  output logic [BITS-1:0]            c,
  output logic                       overflow,
  output logic [$clog2(LENGTH)-1:0]  sample_count
);

  localparam int LOG2  = $clog2(LENGTH);
  localparam int ACC_W = BITS + LOG2;
  localparam logic [LOG2-1:0] LAST = LOG2'(LENGTH - 1);

  // Elaboration-time sanity checks on the configuration.
  if (LENGTH < 2 || LENGTH > 256 || (LENGTH & (LENGTH - 1)) != 0) begin : g_bad_length
    $error("fixed_accumulate: LENGTH must be a power of two in 2..256");
  end
  if (AVERAGE != 0 && AVERAGE != 1) begin : g_bad_average
    $error("fixed_accumulate: AVERAGE must be 0 or 1");
  end
  if (PRECISION == '0) begin : g_bad_precision
    $error("fixed_accumulate: PRECISION tag must not be empty");
  end

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] total;
  logic [LOG2-1:0]         count;
  logic [BITS-1:0]         result;
  logic                    result_ovf;

  assign sample_count = count;

  // Sign-extension by LOG2 bits guarantees LENGTH samples never wrap.
  assign total = acc + $signed({{LOG2{a[BITS-1]}}, a});

  // The sum fits in BITS exactly when the top LOG2+1 bits are all equal.
  // The arithmetic shift right by LOG2 is simply the upper BITS bits of
  // the ACC_W-wide total, so the mean always fits.
  always_comb begin
    result     = total[BITS-1:0];
    result_ovf = 1'b0;
    if (AVERAGE != 0) begin
      result = total[ACC_W-1:LOG2];
    end else begin
      result_ovf = !((&total[ACC_W-1:BITS-1]) || !(|total[ACC_W-1:BITS-1]));
`ifdef FIXED_ACCUMULATE_SATURATE_EN
      if (result_ovf) begin
        result = total[ACC_W-1] ? {1'b1, {(BITS-1){1'b0}}}
                                : {1'b0, {(BITS-1){1'b1}}};
      end
`endif
    end
  end

  // Frame FSM. The LENGTH-th sample dumps the result and returns to IDLE in
  // the same edge, so a sample on the following cycle starts a new frame.
  always_ff @(posedge clk) begin
    out_valid <= 1'b0;
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      c        <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else if (in_valid) begin
      if (state == ACCUM && count == LAST) begin
        state     <= IDLE;
        acc       <= '0;
        count     <= '0;
        c         <= result;
        overflow  <= result_ovf;
        out_valid <= 1'b1;
      end else begin
        state <= ACCUM;
        acc   <= total;
        count <= count + 1'b1;
      end
    end
  end

endmodule
